ofm_drain: RTL and testbench
============================

OFM_DRAIN -- requirements
Module: ofm_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one PE operand; each result is 2*DATA_WIDTH bits wide.
REQ-002 Parameter SYSTOLIC_SIZE, default 16, number of rows and columns in the PE array.
REQ-003 Parameter CAPTURE_DELAY, default 1, number of cycles from drain_start to the first valid ofm_in vector (range 0..7).
REQ-004 Parameter ADDR_WIDTH, default 16, output address width.
REQ-005 clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 drain_start  input  1  one-cycle pulse, coincident with the first cycle of the array's write_out_en window.
REQ-008 base_addr  input  ADDR_WIDTH  destination base address, sampled on an accepted drain_start.
REQ-009 ofm_in  input  SYSTOLIC_SIZE*DATA_WIDTH*2  array output vector; row r is in bits [r*2*DATA_WIDTH +: 2*DATA_WIDTH].
REQ-010 out_valid  output  1  out_data/out_addr/out_last are valid.
REQ-011 out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
REQ-012 out_data  output  SYSTOLIC_SIZE*DATA_WIDTH*2  one captured column vector, same row packing as ofm_in.
REQ-013 out_addr  output  ADDR_WIDTH  base_addr + column index, modulo 2^ADDR_WIDTH.
REQ-014 out_last  output  1  high on the beat carrying column SYSTOLIC_SIZE-1.
REQ-015 busy  output  1  high from the cycle after an accepted drain_start until the last beat is accepted.
REQ-016 done  output  1  one-cycle pulse in the cycle after the last beat is accepted.
REQ-017 overrun  output  1  sticky error flag, cleared only by reset.

Function
REQ-018 FSM states: IDLE, WAIT, CAPTURE, FLUSH.
REQ-019 IDLE: drain_start moves the FSM to WAIT, or directly to CAPTURE when CAPTURE_DELAY=0; base_addr is latched in the same cycle.
REQ-020 WAIT: counts CAPTURE_DELAY-1 further cycles, then moves to CAPTURE, so the first capture occurs exactly CAPTURE_DELAY cycles after drain_start.
REQ-021 CAPTURE: writes ofm_in into buffer entry k on each of SYSTOLIC_SIZE consecutive cycles, k = 0..SYSTOLIC_SIZE-1.
REQ-022 CAPTURE never stalls and ignores out_ready; the buffer depth equals SYSTOLIC_SIZE, so it cannot overflow.
REQ-023 After capture k = SYSTOLIC_SIZE-1, the FSM moves to FLUSH, or directly to IDLE if every beat has already been accepted.
REQ-024 Emission overlaps capture: out_valid is asserted when the read index is less than the write count; entries are emitted in capture order.
REQ-025 A capture of entry k is visible on out_data at the earliest in the next cycle.
REQ-026 out_data, out_addr and out_last are held stable while out_valid && !out_ready.
REQ-027 The read index advances only on an accepted beat.
REQ-028 FLUSH moves to IDLE in the cycle after the beat with out_last is accepted; done pulses in that same IDLE-entry cycle.
REQ-029 drain_start in any state other than IDLE is ignored and sets overrun; data capture in progress is unaffected.
REQ-030 drain_start in the same cycle as the IDLE transition is ignored (the FSM is not yet IDLE) and sets overrun.
REQ-031 No arithmetic is performed on the data; results pass through bit-exact.

Reset
REQ-032 On rst_n low: state=IDLE, all counters=0, and out_valid, out_last, busy, done, overrun=0; out_data=0 and out_addr=0.
REQ-033 Reset asserted mid-capture or mid-flush discards all buffered data; no beat is emitted after reset release until a new drain_start.
REQ-034 Buffer storage contents need no reset.

Structure
REQ-035 FSM state encoding and the default parameters shall live in the shared accelerator package.
REQ-036 One sub-module, ofm_buffer: a SYSTOLIC_SIZE-deep, (SYSTOLIC_SIZE*2*DATA_WIDTH)-wide, one-write/one-read register file.

Verification
REQ-037 CAPTURE_DELAY=1, out_ready=1 constant, ofm_in row r in cycle k = 256*k + r, base_addr=0x100 -> beats at addresses 0x100..0x10F, beat k row r = 256*k + r, out_last on beat 15, done pulses once.
REQ-038 out_ready=0 for 40 cycles after drain_start, then 1 -> all 16 captures are retained and 16 beats are emitted in order, with data held stable while stalled.
REQ-039 out_ready toggling 1,0 every cycle -> 16 beats with no loss or duplication; busy stays high until the last beat is accepted.
REQ-040 Second drain_start at cycle 5 of CAPTURE -> overrun=1 and stays 1; the first transfer completes unchanged.
REQ-041 rst_n low at capture 7 and released two cycles later -> out_valid=0, busy=0, overrun=0; a following drain_start yields a clean 16-beat transfer.
REQ-042 base_addr=0xFFF8 -> out_addr wraps 0xFFF8..0xFFFF, 0x0000..0x0007.

Source files
------------

// File: rtl/ofm_drain_pkg.sv
// Shared definitions for the output-feature-map drain path: FSM encoding and
// default array geometry.
package ofm_drain_pkg;

   localparam int unsigned DefDataWidth    = 8;
   localparam int unsigned DefSystolicSize = 16;
   localparam int unsigned DefCaptureDelay = 1;
   localparam int unsigned DefAddrWidth    = 16;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StCapture,
      StFlush
   } drain_state_e;

endpackage

// File: rtl/ofm_buffer.sv
// One-write/one-read register file holding captured PE column vectors.
// Reads are combinational, so an entry written on an edge is readable next cycle.
module ofm_buffer #(
   parameter int unsigned Depth = 16,
   parameter int unsigned Width = 256,
   localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [IdxW-1:0]  waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [IdxW-1:0]  raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ofm_drain.sv
// Drains one SYSTOLIC_SIZE-column result window from the PE array into a buffer and
// streams it out as addressed beats; emission overlaps capture.
module ofm_drain
   import ofm_drain_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DefDataWidth,
   parameter int unsigned SYSTOLIC_SIZE = DefSystolicSize,
   parameter int unsigned CAPTURE_DELAY = DefCaptureDelay,
   parameter int unsigned ADDR_WIDTH    = DefAddrWidth,
   localparam int unsigned VecW         = SYSTOLIC_SIZE * DATA_WIDTH * 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  drain_start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [VecW-1:0]       ofm_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [VecW-1:0]       out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun
);

   localparam int unsigned IdxW = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
   localparam int unsigned CntW = $clog2(SYSTOLIC_SIZE + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(SYSTOLIC_SIZE - 1);
   localparam logic [CntW-1:0] SizeCnt = CntW'(SYSTOLIC_SIZE);
   localparam logic [2:0]      DlyLast = 3'(CAPTURE_DELAY - 1);

   drain_state_e          state_q, state_d;
   logic [CntW-1:0]       wr_q, wr_d;
   logic [CntW-1:0]       rd_q, rd_d;
   logic [2:0]            dly_q, dly_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic                  done_q, done_d;
   logic                  overrun_q, overrun_d;
   logic                  cap_en;
   logic [IdxW-1:0]       wr_idx;
   logic                  accept;
   logic [VecW-1:0]       rd_data;

   assign out_valid = (state_q != StIdle) && (rd_q < wr_q);
   assign out_last  = out_valid && (rd_q == LastCnt);
   assign out_data  = out_valid ? rd_data : '0;
   assign out_addr  = base_q + ADDR_WIDTH'(rd_q);
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign overrun   = overrun_q;
   assign accept    = out_valid && out_ready;

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      dly_d     = dly_q;
      base_d    = base_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      cap_en    = 1'b0;
      wr_idx    = IdxW'(wr_q);

      if (accept) begin
         rd_d = rd_q + CntW'(1);
      end
      if (drain_start && (state_q != StIdle)) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (drain_start) begin
               base_d = base_addr;
               rd_d   = '0;
               wr_d   = '0;
               dly_d  = '0;
               wr_idx = '0;
               // A zero delay means the first valid vector coincides with the start pulse.
               if (CAPTURE_DELAY == 0) begin
                  cap_en  = 1'b1;
                  wr_d    = CntW'(1);
                  state_d = StCapture;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            dly_d = dly_q + 3'd1;
            if (dly_q == DlyLast) begin
               cap_en  = 1'b1;
               wr_d    = wr_q + CntW'(1);
               state_d = StCapture;
            end
         end
         StCapture: begin
            cap_en = 1'b1;
            wr_d   = wr_q + CntW'(1);
            if (wr_q == LastCnt) begin
               if (rd_d == SizeCnt) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = StFlush;
               end
            end
         end
         StFlush: begin
            if (accept && out_last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         wr_q      <= '0;
         rd_q      <= '0;
         dly_q     <= '0;
         base_q    <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         dly_q     <= dly_d;
         base_q    <= base_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   ofm_buffer #(
      .Depth (SYSTOLIC_SIZE),
      .Width (VecW)
   ) u_buffer (
      .clk_i   (clk),
      .we_i    (cap_en),
      .waddr_i (wr_idx),
      .wdata_i (ofm_in),
      .raddr_i (IdxW'(rd_q)),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_ofm_drain.sv
// Scoreboard bench for ofm_drain at default parameters: expected beats are queued when a
// drain is started and retired by a negedge monitor on every accepted beat.
module tb_ofm_drain;

   localparam int unsigned S    = 16;
   localparam int unsigned VecW = 256;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            drain_start = 1'b0;
   logic [15:0]     base_addr = '0;
   logic [VecW-1:0] ofm_in = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [VecW-1:0] out_data;
   logic [15:0]     out_addr;
   logic            out_last;
   logic            busy;
   logic            done;
   logic            overrun;

   int n_checks = 0;
   int n_err    = 0;
   int done_cnt = 0;

   logic [VecW-1:0] exp_data [$];
   logic [15:0]     exp_addr [$];
   logic            exp_last [$];

   always #5 clk = ~clk;

   ofm_drain u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .drain_start (drain_start),
      .base_addr   (base_addr),
      .ofm_in      (ofm_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_addr    (out_addr),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun)
   );

   task automatic check(input string tag, input logic [VecW-1:0] got,
                        input logic [VecW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [VecW-1:0] vec(input int seed, input int k);
      logic [VecW-1:0] v;
      for (int r = 0; r < int'(S); r++) begin
         v[r*16 +: 16] = 16'(seed * 4096 + 256 * k + r);
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: retires accepted beats, checks stall stability, counts done pulses.
   initial begin
      logic            stalled;
      logic [VecW-1:0] held_data;
      logic [15:0]     held_addr;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (stalled && rst_n) begin
            check("stall_valid", VecW'(out_valid), VecW'(1));
            check("stall_data", out_data, held_data);
            check("stall_addr", VecW'(out_addr), VecW'(held_addr));
         end
         if (out_valid && out_ready) begin
            if (exp_data.size() == 0) begin
               check("unexpected_beat", VecW'(1), VecW'(0));
            end else begin
               check("beat_data", out_data, exp_data.pop_front());
               check("beat_addr", VecW'(out_addr), VecW'(exp_addr.pop_front()));
               check("beat_last", VecW'(out_last), VecW'(exp_last.pop_front()));
            end
         end
         stalled   = out_valid && !out_ready;
         held_data = out_data;
         held_addr = out_addr;
      end
   end

   function automatic logic ready_for(input int mode, input int c);
      case (mode)
         1:       return c > 40;
         2:       return (c % 2) == 0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic push_expected(input int seed, input logic [15:0] base);
      for (int k = 0; k < int'(S); k++) begin
         exp_data.push_back(vec(seed, k));
         exp_addr.push_back(base + 16'(k));
         exp_last.push_back(k == int'(S) - 1);
      end
   endtask

   task automatic run_transfer(input int seed, input logic [15:0] base, input int mode,
                               input int extra_c);
      int d0;
      int c;
      bit fin;
      d0  = done_cnt;
      c   = 0;
      fin = 1'b0;
      push_expected(seed, base);
      while (!fin && c < 300) begin
         drain_start = (c == 0) || (c == extra_c);
         base_addr   = (c == 0) ? base : 16'hDEAD;
         ofm_in      = (c >= 1 && c <= int'(S)) ? vec(seed, c - 1) : {8{$urandom()}};
         out_ready   = ready_for(mode, c);
         tick();
         c++;
         if (exp_data.size() != 0) begin
            check("busy_high", VecW'(busy), VecW'(1));
         end else begin
            check("done_pulse", VecW'(done), VecW'(1));
            check("busy_low", VecW'(busy), VecW'(0));
            fin = 1'b1;
         end
      end
      if (!fin) begin
         check("drain_timeout", VecW'(exp_data.size()), VecW'(0));
         exp_data.delete();
         exp_addr.delete();
         exp_last.delete();
      end
      drain_start = 1'b0;
      out_ready   = 1'b1;
      tick();
      check("done_once", VecW'(done_cnt - d0), VecW'(1));
      check("idle_valid", VecW'(out_valid), VecW'(0));
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_valid", VecW'(out_valid), VecW'(0));
      check("rst_last", VecW'(out_last), VecW'(0));
      check("rst_busy", VecW'(busy), VecW'(0));
      check("rst_done", VecW'(done), VecW'(0));
      check("rst_overrun", VecW'(overrun), VecW'(0));
      check("rst_data", out_data, '0);
      check("rst_addr", VecW'(out_addr), VecW'(0));
      rst_n = 1'b1;
      tick();
      tick();

      run_transfer(0, 16'h0100, 0, -1);
      run_transfer(1, 16'h0200, 1, -1);
      run_transfer(2, 16'h0400, 2, -1);
      run_transfer(3, 16'hFFF8, 0, -1);
      check("overrun_clear", VecW'(overrun), VecW'(0));

      // Second start during capture cycle 5 must be ignored but flagged.
      run_transfer(4, 16'h0500, 0, 6);
      check("overrun_set", VecW'(overrun), VecW'(1));
      tick();
      tick();
      check("overrun_sticky", VecW'(overrun), VecW'(1));

      // Reset in the cycle of capture 7.
      push_expected(5, 16'h0600);
      for (int c = 0; c < 8; c++) begin
         drain_start = (c == 0);
         base_addr   = 16'h0600;
         ofm_in      = (c >= 1) ? vec(5, c - 1) : '0;
         out_ready   = 1'b1;
         tick();
      end
      ofm_in = vec(5, 7);
      rst_n  = 1'b0;
      exp_data.delete();
      exp_addr.delete();
      exp_last.delete();
      #1;
      check("mid_rst_valid", VecW'(out_valid), VecW'(0));
      check("mid_rst_busy", VecW'(busy), VecW'(0));
      check("mid_rst_overrun", VecW'(overrun), VecW'(0));
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ofm_in = {8{$urandom()}};
         tick();
         check("post_rst_valid", VecW'(out_valid), VecW'(0));
         check("post_rst_busy", VecW'(busy), VecW'(0));
      end
      check("post_rst_overrun", VecW'(overrun), VecW'(0));
      run_transfer(6, 16'h0700, 0, -1);
      check("final_overrun", VecW'(overrun), VecW'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
